// File: rtl/dmem_arbiter.sv
// ============================================================================
// Module      : dmem_arbiter
// Description : Two-port arbiter sharing one Data_Memory line port between a
//               dcache requester (port 0) and a second line requester (port 1).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dmem_arbiter #(
    parameter int RR_EN   = 1,
    parameter int TIMEOUT = 64
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         req0_enable_i,
    input  logic         req0_write_i,
    input  logic [31:0]  req0_addr_i,
    input  logic [255:0] req0_data_i,
    output logic         req0_ack_o,
    input  logic         req1_enable_i,
    input  logic         req1_write_i,
    input  logic [31:0]  req1_addr_i,
    input  logic [255:0] req1_data_i,
    output logic         req1_ack_o,
    output logic [255:0] req_data_o,
    output logic         mem_enable_o,
    output logic         mem_write_o,
    output logic [31:0]  mem_addr_o,
    output logic [255:0] mem_data_o,
    input  logic         mem_ack_i,
    input  logic [255:0] mem_data_i,
    output logic         grant_o,
    output logic [31:0]  cnt0_o,
    output logic [31:0]  cnt1_o,
    output logic         err_timeout_o
);

    localparam logic [1:0]  c_IDLE    = 2'd0;
    localparam logic [1:0]  c_BUSY    = 2'd1;
    localparam logic [1:0]  c_RELEASE = 2'd2;
    localparam logic [15:0] c_TIMEOUT = 16'(TIMEOUT);
    localparam logic        c_RR      = (RR_EN != 0);

    logic [1:0]   r_state;
    logic [1:0]   w_next;
    logic         r_grant;
    logic         r_mem_write;
    logic [31:0]  r_mem_addr;
    logic [255:0] r_mem_data;
    logic [31:0]  r_cnt0;
    logic [31:0]  r_cnt1;
    logic [15:0]  r_wait;
    logic         r_err;

    logic w_busy;
    logic w_req_any;
    logic w_pick1;
    logic w_ack_hit;
    logic w_timeout_hit;

    assign w_busy        = (r_state == c_BUSY);
    assign w_req_any     = req0_enable_i | req1_enable_i;
    // Port 1 wins when alone, or on a tie under round-robin when port 0 went last.
    assign w_pick1       = req1_enable_i & (~req0_enable_i | (c_RR & ~r_grant));
    assign w_ack_hit     = w_busy & mem_ack_i;
    assign w_timeout_hit = w_busy & (r_wait == c_TIMEOUT);

    always_comb begin
        w_next = r_state;
        case (r_state)
            c_IDLE:    if (w_req_any) w_next = c_BUSY;
            c_BUSY:    if (mem_ack_i) w_next = c_RELEASE;
            c_RELEASE: w_next = c_IDLE;
            default:   w_next = c_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) r_state <= c_IDLE;
        else       r_state <= w_next;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_grant     <= 1'b1;
            r_mem_write <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_data  <= '0;
        end else if ((r_state == c_IDLE) && w_req_any) begin
            r_grant     <= w_pick1;
            r_mem_write <= w_pick1 ? req1_write_i : req0_write_i;
            r_mem_addr  <= w_pick1 ? req1_addr_i  : req0_addr_i;
            r_mem_data  <= w_pick1 ? req1_data_i  : req0_data_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_cnt0 <= '0;
            r_cnt1 <= '0;
        end else if (w_ack_hit) begin
            if (r_grant) r_cnt1 <= r_cnt1 + 32'd1;
            else         r_cnt0 <= r_cnt0 + 32'd1;
        end
    end

    // r_wait holds the 1-based index of the current BUSY cycle, saturating at TIMEOUT.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wait <= '0;
            r_err  <= 1'b0;
        end else begin
            if ((r_state == c_IDLE) && w_req_any)
                r_wait <= 16'd1;
            else if (w_busy && !mem_ack_i && (r_wait != c_TIMEOUT))
                r_wait <= r_wait + 16'd1;
            r_err <= r_err | w_timeout_hit;
        end
    end

    assign req0_ack_o    = w_ack_hit & ~r_grant;
    assign req1_ack_o    = w_ack_hit &  r_grant;
    assign req_data_o    = mem_data_i;
    assign mem_enable_o  = w_busy;
    assign mem_write_o   = r_mem_write;
    assign mem_addr_o    = r_mem_addr;
    assign mem_data_o    = r_mem_data;
    assign grant_o       = r_grant;
    assign cnt0_o        = r_cnt0;
    assign cnt1_o        = r_cnt1;
    assign err_timeout_o = r_err | w_timeout_hit;

endmodule

`default_nettype wire

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-port arbiter sharing the single Data_Memory port (256-bit line, enable/write/ack handshake) between requester 0 (dcache refill/write-back) and requester 1 (instruction-line fetch or write buffer).
- Sits between the CPU-side line requesters and Data_Memory.
- Latches one request at a time, drives it to memory until ack, routes the ack back to the winner, and keeps per-port transaction counters plus a timeout flag for debug.

Parameters:
- RR_EN, 1, 1 = round-robin on simultaneous requests; 0 = fixed priority, port 0 wins.
- TIMEOUT, 64, cycles in BUSY without mem_ack_i before err_timeout_o sets (1..65535).

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous active-high reset
- req0_enable_i  in  1  port 0 request, held high until req0_ack_o
- req0_write_i  in  1  port 0: 1 = write line, 0 = read line
- req0_addr_i  in  32  port 0 byte address (bits [4:0] ignored by memory)
- req0_data_i  in  256  port 0 write line
- req0_ack_o  out  1  port 0 transaction done (1 cycle)
- req1_enable_i, req1_write_i, req1_addr_i, req1_data_i, req1_ack_o: same as port 0
- req_data_o  out  256  read line, mem_data_i broadcast to both ports
- mem_enable_o  out  1  to Data_Memory enable_i
- mem_write_o  out  1  to Data_Memory write_i
- mem_addr_o  out  32  to Data_Memory addr_i
- mem_data_o  out  256  to Data_Memory data_i
- mem_ack_i  in  1  from Data_Memory ack_o
- mem_data_i  in  256  from Data_Memory data_o
- grant_o  out  1  index of the port owning the current or last transaction
- cnt0_o, cnt1_o  out  32  completed transactions per port, wrap at 2^32
- err_timeout_o  out  1  sticky timeout flag

Behaviour:
- Reset (async, immediate):
  - State IDLE; mem_enable_o, mem_write_o, req*_ack_o, err_timeout_o = 0.
  - mem_addr_o, mem_data_o, cnt0_o, cnt1_o = 0.
  - grant_o = 1, so the first tie under RR goes to port 0.
  - Reset mid-BUSY drops mem_enable_o immediately and abandons the transaction. Nothing is replayed.
- FSM: IDLE, BUSY, RELEASE.
- IDLE:
  - No reqX_enable_i: stay in IDLE.
  - One request: that port is the winner.
  - Both requesting: RR_EN=1 picks the port != grant_o; RR_EN=0 picks port 0.
  - On the clock edge: latch the winner's write/addr/data into mem_*_o, set grant_o, set mem_enable_o=1, go to BUSY.
  - mem_enable_o therefore rises 1 cycle after the request is first seen.
- BUSY:
  - mem_enable_o=1; mem_write_o, mem_addr_o, mem_data_o held stable from the latch. Requester input changes are ignored.
  - reqG_ack_o = mem_ack_i & (grant==G), combinational, same cycle as mem_ack_i. The loser's ack stays 0.
  - On the mem_ack_i edge: mem_enable_o=0, increment cnt of the granted port, go to RELEASE.
  - Cycle counter increments each BUSY cycle without ack. When it reaches TIMEOUT, err_timeout_o=1 (sticky until reset). The FSM keeps waiting; there is no abort.
- RELEASE:
  - One cycle, mem_enable_o=0, so Data_Memory sees enable low between transactions and the acked requester can drop its enable. Then go to IDLE.
  - A request still high in IDLE is a new transaction.
  - Minimum spacing: mem_enable_o low for 2 cycles between back-to-back grants.
- req_data_o = mem_data_i at all times. It is valid only in the reqG_ack_o cycle.
- Protocol violations:
  - Requester dropping enable before ack: the transaction still completes and the ack is still pulsed.
  - mem_ack_i in IDLE or RELEASE: ignored; no ack out, no count.
- Counters wrap 0xFFFFFFFF -> 0.

Test Plan:
1. Single read, memory model acks 10 cycles after enable: req0 read addr 0x00000020 at cycle 2 -> mem_enable_o rises cycle 3 with addr 0x20, write 0; req0_ack_o exactly one cycle (cycle 13); req_data_o = 0x8888_9999_..._0000; cnt0_o=1; req1_ack_o never high.
2. Simultaneous requests, RR_EN=1: req0 write addr 0x200, req1 read addr 0x400, both at cycle 2 -> port 0 served first (grant_o=0), then after RELEASE port 1 (grant_o=1); mem_enable_o low for exactly 2 cycles between them; each port acked once; a subsequent tie goes to port 0.
3. Fixed priority, RR_EN=0: both ports hold requests continuously for 3 transactions -> all 3 grants to port 0; cnt0_o=3, cnt1_o=0.
4. Input stability: during port 0 BUSY, change req0_addr_i from 0x40 to 0x240 -> mem_addr_o stays 0x40 until ack; write data of 256'hECFA… reaches memory unchanged.
5. Timeout: TIMEOUT=16, memory never acks -> err_timeout_o=1 on the 16th BUSY cycle; mem_enable_o stays 1; a later ack completes normally and err_timeout_o remains 1.
6. Async reset mid-BUSY (rst_i pulsed between edges) -> mem_enable_o=0 immediately, no ack issued, counters 0, grant_o=1; a fresh req1 afterwards is served normally.
